// File: rtl/cache_lookup_ctrl.sv
// Request front-end for the 8-entry key/value cache: looks keys up, fills misses from
// backing memory and returns exactly one response per accepted request.
module cache_lookup_ctrl #(
    parameter int KEY_W   = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [KEY_W-1:0]  req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              rsp_err,
    output logic              find,
    output logic [KEY_W-1:0]  key,
    input  logic              match_found,
    input  logic [DATA_W-1:0] read_value,
    output logic              update,
    output logic [DATA_W-1:0] update_value,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [KEY_W-1:0]  mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } state_t;

    state_t state_reg, state_next;

    logic [KEY_W-1:0]   key_reg;
    logic [DATA_W-1:0]  rsp_data_reg;
    logic [DATA_W-1:0]  update_value_reg;
    logic               rsp_hit_reg;
    logic               rsp_err_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic               timer_expired;
    logic               rsp_done;
    logic [1:0]         cnt_inc;
    logic [2*CNT_W-1:0] cnt_flat;

    // The last permitted MEM_WAIT cycle is the one where the timer reads TIMEOUT-1.
    assign timer_expired = (timer_reg == TMR_W'(TIMEOUT - 1));
    assign rsp_done      = (state_reg == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (req_valid) state_next = LOOKUP;
            LOOKUP:   state_next = CHECK;
            CHECK:    state_next = match_found ? RESP : MEM_REQ;
            MEM_REQ:  if (mem_req_ready) state_next = MEM_WAIT;
            // A response arriving on the limit cycle still counts as a normal fill.
            MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = FILL;
                end else if (timer_expired) begin
                    state_next = RESP;
                end
            end
            FILL:     state_next = RESP;
            RESP:     if (rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        find          = 1'b0;
        update        = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        case (state_reg)
            IDLE:    req_ready     = 1'b1;
            LOOKUP:  find          = 1'b1;
            MEM_REQ: mem_req_valid = 1'b1;
            FILL:    update        = 1'b1;
            RESP:    rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_reg          <= '0;
            rsp_data_reg     <= '0;
            update_value_reg <= '0;
            rsp_hit_reg      <= 1'b0;
            rsp_err_reg      <= 1'b0;
            timer_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) key_reg <= req_key;
                end
                CHECK: begin
                    if (match_found) begin
                        rsp_data_reg <= read_value;
                        rsp_hit_reg  <= 1'b1;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) timer_reg <= '0;
                end
                MEM_WAIT: begin
                    timer_reg <= timer_reg + TMR_W'(1);
                    if (mem_rsp_valid) begin
                        update_value_reg <= mem_rsp_data;
                        rsp_data_reg     <= mem_rsp_data;
                    end else if (timer_expired) begin
                        rsp_err_reg  <= 1'b1;
                        rsp_data_reg <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_hit_reg <= 1'b0;
                        rsp_err_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Index 0 counts hits, index 1 counts misses (timeouts are misses too).
    assign cnt_inc[0] = rsp_done && rsp_hit_reg;
    assign cnt_inc[1] = rsp_done && !rsp_hit_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign key          = key_reg;
    assign mem_addr     = key_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_hit      = rsp_hit_reg;
    assign rsp_err      = rsp_err_reg;
    assign update_value = update_value_reg;
    assign hit_cnt      = cnt_flat[CNT_W-1:0];
    assign miss_cnt     = cnt_flat[2*CNT_W-1:CNT_W];

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Randomised bench for cache_lookup_ctrl: emulates the cache and backing memory, and keeps a
// FIFO-replacement reference of cache contents plus saturating reference counters.
module tb_cache_lookup_ctrl;

    localparam int KEY_W     = 8;
    localparam int DATA_W    = 8;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int TXN_LIMIT = 200;

    logic              clk           = 1'b0;
    logic              reset_n       = 1'b0;
    logic              req_valid     = 1'b0;
    logic              req_ready;
    logic [KEY_W-1:0]  req_key       = '0;
    logic              rsp_valid;
    logic              rsp_ready     = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_hit;
    logic              rsp_err;
    logic              find;
    logic [KEY_W-1:0]  key;
    logic              match_found   = 1'b0;
    logic [DATA_W-1:0] read_value    = '0;
    logic              update;
    logic [DATA_W-1:0] update_value;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [KEY_W-1:0]  mem_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data  = '0;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    cache_lookup_ctrl #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .find(find), .key(key), .match_found(match_found), .read_value(read_value),
        .update(update), .update_value(update_value),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Cache emulation: registered match one cycle after find, FIFO slot replacement on update.
    logic [7:0] cache_key [8];
    logic [7:0] cache_val [8];
    int         cache_ptr    = 0;
    bit         cache_loaded = 1'b0;

    always @(posedge clk) begin
        if (!cache_loaded) begin
            for (int i = 0; i < 8; i++) begin
                cache_key[i] <= 8'(i + 1);
                cache_val[i] <= 8'(i + 51);
            end
            cache_loaded <= 1'b1;
        end else begin
            match_found <= 1'b0;
            read_value  <= '0;
            if (find) begin
                for (int i = 0; i < 8; i++) begin
                    if (cache_key[i] == key) begin
                        match_found <= 1'b1;
                        read_value  <= cache_val[i];
                    end
                end
            end
            if (update) begin
                cache_key[cache_ptr] <= key;
                cache_val[cache_ptr] <= update_value;
                cache_ptr            <= (cache_ptr + 1) % 8;
            end
        end
    end

    // Reference contents: map of key to value, queue holds insertion order for eviction.
    bit [7:0] ref_val [bit [7:0]];
    bit [7:0] ref_order [$];
    int       hit_ref  = 0;
    int       miss_ref = 0;

    task automatic apply_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        rsp_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        hit_ref  = 0;
        miss_ref = 0;
    endtask

    task automatic run_txn(input logic [7:0] k, input logic [7:0] mem_data, input int req_stall,
                           input int mem_lat, input int rsp_stall);
        bit         exp_hit, exp_err, exp_upd;
        logic [7:0] exp_data;
        int         exp_lat;
        int         c, lat, nfind, find_cyc, nupd, mreq_n, wait_cnt, rsp_n;
        bit         hs, seen, accepted, key_bad, hold_bad, busy_bad, both_bad;
        logic [7:0] got_data, upd_key, upd_val;
        logic       got_hit, got_err;

        exp_hit = ref_val.exists(k);
        exp_err = 1'b0;
        exp_upd = 1'b0;
        if (exp_hit) begin
            exp_data = ref_val[k];
            exp_lat  = 3;
        end else if (mem_lat > TIMEOUT) begin
            exp_data = 8'h00;
            exp_err  = 1'b1;
            exp_lat  = 4 + req_stall + TIMEOUT;
        end else begin
            exp_data = mem_data;
            exp_upd  = 1'b1;
            exp_lat  = 5 + req_stall + mem_lat;
        end

        c = 0; lat = -1; nfind = 0; find_cyc = -1; nupd = 0; mreq_n = 0; wait_cnt = 0; rsp_n = 0;
        hs = 0; seen = 0; accepted = 0; key_bad = 0; hold_bad = 0; busy_bad = 0; both_bad = 0;
        got_data = 'x; got_hit = 'x; got_err = 'x; upd_key = 'x; upd_val = 'x;

        @(negedge clk);
        req_valid = 1'b1;
        req_key   = k;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL req_ready_idle key=%h: got %b want 1", k, req_ready);
        end

        while (!accepted && c < TXN_LIMIT) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                req_valid = 1'b0;
                req_key   = 8'($urandom);
            end
            if (rsp_ready) begin
                accepted  = 1'b1;
                rsp_ready = 1'b0;
            end else begin
                if (find) begin nfind++; find_cyc = c; end
                if (find && update) both_bad = 1'b1;
                if (update) begin nupd++; upd_key = key; upd_val = update_value; end
                if (key !== k || mem_addr !== k) key_bad = 1'b1;
                if (req_ready !== 1'b0) busy_bad = 1'b1;
                if (mem_rsp_valid) mem_rsp_valid = 1'b0;
                if (hs) begin
                    mem_req_ready = 1'b0;
                    wait_cnt++;
                    if (wait_cnt == mem_lat) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = mem_data;
                    end
                end else if (mem_req_valid) begin
                    if (mreq_n >= req_stall) begin
                        mem_req_ready = 1'b1;
                        hs            = 1'b1;
                    end
                    mreq_n++;
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen = 1'b1; lat = c;
                        got_data = rsp_data; got_hit = rsp_hit; got_err = rsp_err;
                    end else if (rsp_data !== got_data || rsp_hit !== got_hit || rsp_err !== got_err) begin
                        hold_bad = 1'b1;
                    end
                    if (rsp_n >= rsp_stall) rsp_ready = 1'b1;
                    rsp_n++;
                end
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        rsp_ready     = 1'b0;

        tests_run++;
        if (!accepted) begin
            tests_failed++;
            $display("FAIL rsp_handshake key=%h: no response within %0d cycles", k, TXN_LIMIT);
        end
        tests_run++;
        if (lat != exp_lat) begin
            tests_failed++;
            $display("FAIL latency key=%h: got %0d want %0d", k, lat, exp_lat);
        end
        tests_run++;
        if ({got_data, got_hit, got_err} !== {exp_data, exp_hit, exp_err}) begin
            tests_failed++;
            $display("FAIL response key=%h: got data=%h hit=%b err=%b want data=%h hit=%b err=%b",
                     k, got_data, got_hit, got_err, exp_data, exp_hit, exp_err);
        end
        tests_run++;
        if (nfind != 1 || find_cyc != 1) begin
            tests_failed++;
            $display("FAIL find_pulse key=%h: got %0d pulses at cycle %0d want 1 at cycle 1", k, nfind, find_cyc);
        end
        tests_run++;
        if (nupd != int'(exp_upd) || (exp_upd && {upd_key, upd_val} !== {k, mem_data})) begin
            tests_failed++;
            $display("FAIL update key=%h: got %0d pulses key=%h val=%h want %0d pulses val=%h",
                     k, nupd, upd_key, upd_val, exp_upd, mem_data);
        end
        tests_run++;
        if ({key_bad, hold_bad, busy_bad, both_bad} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL stability key=%h: got key_bad=%b hold_bad=%b busy_bad=%b both_bad=%b want all 0",
                     k, key_bad, hold_bad, busy_bad, both_bad);
        end
        tests_run++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_err} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL back_to_idle key=%h: got %b want 1000", k, {req_ready, rsp_valid, rsp_hit, rsp_err});
        end

        if (exp_hit) begin
            if (hit_ref < CNT_MAX) hit_ref++;
        end else begin
            if (miss_ref < CNT_MAX) miss_ref++;
        end
        if (exp_upd) begin
            if (ref_order.size() >= 8) ref_val.delete(ref_order.pop_front());
            ref_order.push_back(k);
            ref_val[k] = mem_data;
        end
        tests_run++;
        if (hit_cnt !== CNT_W'(hit_ref) || miss_cnt !== CNT_W'(miss_ref)) begin
            tests_failed++;
            $display("FAIL counters key=%h: got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     k, hit_cnt, miss_cnt, hit_ref, miss_ref);
        end
        $display("[TB] txn key=%h hit=%b err=%b data=%h lat=%0d hit_cnt=%0d miss_cnt=%0d",
                 k, got_hit, got_err, got_data, lat, hit_cnt, miss_cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        tests_run++;
        if ({rsp_valid, rsp_hit, rsp_err, find, update, mem_req_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_controls: got %b want 000000",
                     {rsp_valid, rsp_hit, rsp_err, find, update, mem_req_valid});
        end
        tests_run++;
        if ({rsp_data, key, update_value, mem_addr, hit_cnt, miss_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got data=%h key=%h uval=%h addr=%h hit=%0d miss=%0d want all 0",
                     rsp_data, key, update_value, mem_addr, hit_cnt, miss_cnt);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, find} !== 3'b100) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b want 100", {req_ready, rsp_valid, find});
        end
    endtask

    task automatic test_hit();
        run_txn(8'h03, 8'h00, 0, 1, 0);
        run_txn(8'h08, 8'h00, 0, 1, 0);
    endtask

    task automatic test_miss_fill();
        run_txn(8'h20, 8'hA5, 0, 4, 0);
        run_txn(8'h20, 8'h00, 0, 4, 0);
    endtask

    task automatic test_timeout();
        bit quiet_bad = 1'b0;
        run_txn(8'h40, 8'($urandom), 0, TIMEOUT + 4, 8);
        run_txn(8'h40, 8'($urandom), 0, TIMEOUT, 0);
        run_txn(8'h41, 8'($urandom), 0, TIMEOUT + 1, 0);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'h99;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            if (update || rsp_valid || find || !req_ready) quiet_bad = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (quiet_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_rsp_ignored: got activity=%b want 0", quiet_bad);
        end
        run_txn(8'h41, 8'h5A, 0, 2, 0);
    endtask

    task automatic test_backpressure();
        run_txn(8'h50, 8'($urandom), 3, 4, 5);
        run_txn(8'h50, 8'h00, 0, 1, 5);
    endtask

    task automatic test_reset_mid_wait();
        bit got_req   = 1'b0;
        bit stray_bad = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = 8'h60;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                got_req       = 1'b1;
                mem_req_ready = 1'b1;
            end
        end
        tests_run++;
        if (!got_req) begin
            tests_failed++;
            $display("FAIL mid_wait_memreq: no mem_req_valid within 10 cycles");
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_wait_busy: got %b want 00", {req_ready, rsp_valid});
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset_ready: got %b want 1", req_ready);
        end
        tests_run++;
        if ({rsp_valid, rsp_hit, rsp_err, find, update, mem_req_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL async_reset_controls: got %b want 000000",
                     {rsp_valid, rsp_hit, rsp_err, find, update, mem_req_valid});
        end
        tests_run++;
        if ({rsp_data, key, update_value, mem_addr, hit_cnt, miss_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_data: got data=%h key=%h uval=%h addr=%h hit=%0d miss=%0d want all 0",
                     rsp_data, key, update_value, mem_addr, hit_cnt, miss_cnt);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        hit_ref  = 0;
        miss_ref = 0;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'h77;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            if (update || rsp_valid || find || mem_req_valid || !req_ready) stray_bad = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (stray_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_mem_rsp: got activity=%b want 0", stray_bad);
        end
        run_txn(8'h60, 8'($urandom), 0, 3, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn(8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3),
                    $urandom_range(1, TIMEOUT + 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_hit_saturation();
        apply_reset();
        for (int n = 0; n < 20; n++) begin
            run_txn(ref_order[$urandom_range(0, ref_order.size() - 1)], 8'h00, 0, 1, 0);
        end
        tests_run++;
        if (hit_cnt !== 4'd15 || miss_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL hit_saturation: got hit=%0d miss=%0d want hit=15 miss=0", hit_cnt, miss_cnt);
        end
    endtask

    initial begin
        for (int i = 1; i <= 8; i++) begin
            ref_val[8'(i)] = 8'(i + 50);
            ref_order.push_back(8'(i));
        end
        test_reset();
        test_hit();
        test_miss_fill();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        test_hit_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
